// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller sitting
// between a CPU request port and a single-port word RAM; counts hits/misses.
module dm_cache_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 10,
  parameter int INDEX_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cache_flush,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int LINES = 2 ** INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, COMPARE, FILL, WRITE} state_t;

  state_t state, state_next;

  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [DATA_W-1:0]  data_mem [LINES];

  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;
  logic               req_we;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;

  assign idx = req_addr[INDEX_W-1:0];
  assign tag = req_addr[ADDR_W-1:INDEX_W];
  assign hit = valid[idx] && (tag_mem[idx] == tag);

  // Decoded straight from the state register so an async reset kills the
  // RAM write strobe immediately.
  assign mem_we      = (state == WRITE);
  assign cpu_busy    = (state != IDLE);
  assign mem_address = req_addr;
  assign mem_wdata   = req_wdata;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!cache_flush && cpu_req) state_next = COMPARE;
      COMPARE: begin
        if (req_we)    state_next = WRITE;
        else if (!hit) state_next = FILL;
        else           state_next = IDLE;
      end
      FILL:    state_next = IDLE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      valid      <= '0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_we     <= 1'b0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state     <= state_next;
      cpu_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cache_flush) begin
            valid <= '0;
          end else if (cpu_req) begin
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            req_we    <= cpu_we;
          end
        end
        COMPARE: begin
          if (hit) begin
            if (hit_count != CNT_MAX) hit_count <= hit_count + CNT_W'(1);
            if (!req_we) begin
              cpu_rdata <= data_mem[idx];
              cpu_ready <= 1'b1;
            end
          end else begin
            if (miss_count != CNT_MAX) miss_count <= miss_count + CNT_W'(1);
          end
        end
        FILL: begin
          valid[idx] <= 1'b1;
          cpu_rdata  <= mem_rdata;
          cpu_ready  <= 1'b1;
        end
        WRITE: cpu_ready <= 1'b1;
        default: ;
      endcase
    end
  end

  // Tag/data storage carries no reset; valid bits alone gate its use.
  always_ff @(posedge clk) begin
    if (state == COMPARE && req_we && hit) data_mem[idx] <= req_wdata;
    if (state == FILL) begin
      data_mem[idx] <= mem_rdata;
      tag_mem[idx]  <= tag;
    end
  end

endmodule
